serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
Programmable serial bit-pattern transmitter: the driving end of the single-bit serial stream that the team's sequence detectors consume.
- Accepts a pattern word, bit length and repeat count through a valid/ready load handshake.
- Shifts the pattern out MSB-first, one bit per clock on dout, qualified by dout_en.
- Repeats are emitted back-to-back with no gap, so overlapping and non-overlapping detection can both be exercised.

Parameters:
PAT_W, 8, maximum pattern width in bits (>=2)
LEN_W, 4, width of load_len; must hold values 0..PAT_W
REP_W, 4, width of load_reps

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
load_valid  input  1  load request
load_ready  output  1  high only when IDLE and abort low (combinational)
load_pattern  input  PAT_W  bits to send; bit load_len-1 goes first
load_len  input  LEN_W  number of bits per repetition (0..PAT_W)
load_reps  input  REP_W  number of repetitions
abort  input  1  synchronous cancel of the current transmission
dout  output  1  serial data, registered; 0 whenever dout_en=0
dout_en  output  1  dout carries a valid bit this cycle, registered
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle completion pulse, registered

Behaviour:
- The module has one clock, clk. Reset rst is asynchronous and active-high.
- Reset forces the state to IDLE and drives dout=0, dout_en=0, busy=0 and done=0. It also clears the pattern, length, bit-index and repeat registers.
- Reset asserted mid-transmission takes effect immediately, with no wait for an edge.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - A handshake (load_valid && load_ready at an edge) captures load_pattern, load_len and load_reps.
  - If load_len=0 or load_reps=0, go to DONE; nothing is transmitted.
  - Otherwise go to SHIFT with bit index = load_len-1 and repeats remaining = load_reps.
- Latency: if the handshake is at edge N, the first bit is on dout with dout_en=1 from edge N+1.
- SHIFT, one bit per cycle:
  - dout = pattern[index] and dout_en = 1.
  - At index 0 with repeats remaining >1: reload index to len-1 and decrement the repeat count. There is no idle cycle between repeats.
  - At index 0 with repeats remaining =1: go to DONE.
  - A full transmission occupies exactly len*reps consecutive dout_en cycles.
- DONE lasts one cycle: done=1, dout_en=0, dout=0, load_ready=0. It then returns to IDLE.
  - Handshake N with no transmission (len or reps = 0) gives done high from edge N+1.
  - Otherwise done is high in the cycle immediately after the last bit.
- Abort:
  - abort sampled high in SHIFT returns to IDLE at that edge: dout_en=0, dout=0, no done pulse, repeat count discarded.
  - abort in DONE still completes DONE (done pulses).
  - abort in IDLE blocks the load, because load_ready is low.
- load_valid while busy is ignored; no stall and no queueing.
- load_len > PAT_W is clamped to PAT_W at capture.
- Pattern bits above load_len-1 are don't-care.
- The capture registers are frozen during transmission, so input changes after the handshake have no effect.
- Counter widths: the bit index is LEN_W bits and the repeat count is REP_W bits. There is no wrap, because reload happens on index 0.

Decomposition:
- Shared package serial_tx_pkg holds:
  - the state encoding constants ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10;
  - default PAT_W/LEN_W/REP_W constants;
  - a load-request struct/typedef (pattern, len, reps).
- One natural sub-module: piso_shift_reg. It is a parallel-in serial-out register with load, shift-enable and index-select, and it produces dout.
- The top level keeps the FSM, the repeat counter and the handshake.

Test Plan:
1. Basic send: handshake with load_pattern=8'h0A, len=4, reps=1 -> dout = 1,0,1,0 over 4 cycles with dout_en=1; done=1 in cycle 5; load_ready=1 in cycle 6.
2. Back-to-back repeats: pattern 4'b1010, len=4, reps=3 -> 12 contiguous dout_en cycles carrying 101010101010; a 1010 detector sees 5 matches overlapping and 3 matches non-overlapping; a single done pulse.
3. Degenerate loads: len=0 reps=5, then len=3 reps=0 -> dout_en never asserts; done pulses the cycle after each handshake; load_len=15 is clamped to 8 bits sent.
4. Abort: abort asserted on the 3rd bit of pattern 8'hB5, len=8, reps=2 -> dout_en low from that edge; no done pulse; load_ready=1; a new load is accepted the next cycle.
5. Async reset mid-transmission: rst pulsed between edges during bit 2 -> dout, dout_en and busy go 0 immediately without a clock edge; IDLE after release; a subsequent load behaves as in scenario 1.
6. Busy protection: load_valid held high throughout scenario 1 with a different pattern -> the second load is accepted only after the DONE cycle, and the first stream is unchanged.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Holds the state encoding, default widths and the load-request record.
package serial_tx_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int REP_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    typedef struct packed {
        logic [PAT_W_DEF-1:0] pattern;
        logic [LEN_W_DEF-1:0] len;
        logic [REP_W_DEF-1:0] reps;
    } load_req_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: holds the pattern and registers the bit
// selected by idx onto dout while shift_en is high, otherwise drives 0.
module piso_shift_reg #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] load_pattern,
    input  logic             shift_en,
    input  logic [LEN_W-1:0] idx,
    output logic             dout,
    output logic             dout_en
);

    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [PAT_W-1:0] sel_mask;
    logic             dout_q, dout_d;
    logic             dout_en_q, dout_en_d;

    // The loading edge must already present the first bit, so select from
    // the incoming word on a load rather than from the stored copy.
    always_comb begin
        pattern_d = load ? load_pattern : pattern_q;
        sel_mask  = PAT_W'(1) << idx;
        dout_d    = shift_en && ((pattern_d & sel_mask) != '0);
        dout_en_d = shift_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= '0;
            dout_q    <= 1'b0;
            dout_en_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
        end
    end

    assign dout    = dout_q;
    assign dout_en = dout_en_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// Programmable serial bit-pattern transmitter: loads a pattern, length and
// repeat count, then streams the pattern MSB-first with back-to-back repeats.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] load_pattern,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_reps,
    input  logic             abort,
    output logic             dout,
    output logic             dout_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_clamped;
    logic             fire;
    logic             shift_en;

    // Load handshake: a transfer happens on any rising edge where load_valid
    // and load_ready are both high; load_ready never depends on load_valid.
    always_comb begin
        len_clamped = (load_len > LEN_MAX) ? LEN_MAX : load_len;
        load_ready  = (state_q == ST_IDLE) && !abort;
        fire        = load_valid && load_ready;
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        reps_d      = reps_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    len_d  = len_clamped;
                    reps_d = load_reps;
                    if (len_clamped == '0 || load_reps == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                        idx_d   = len_clamped - LEN_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    reps_d  = '0;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - LEN_W'(1);
                end else if (reps_q > REP_W'(1)) begin
                    // Reload on the last bit so the next repeat follows with no gap.
                    idx_d  = len_q - LEN_W'(1);
                    reps_d = reps_q - REP_W'(1);
                end else begin
                    state_d = ST_DONE;
                    reps_d  = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        done_d   = (state_d == ST_DONE);
        shift_en = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            reps_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
            done_q  <= done_d;
        end
    end

    piso_shift_reg #(
        .PAT_W(PAT_W),
        .LEN_W(LEN_W)
    ) u_piso (
        .clk         (clk),
        .rst         (rst),
        .load        (fire),
        .load_pattern(load_pattern),
        .shift_en    (shift_en),
        .idx         (idx_d),
        .dout        (dout),
        .dout_en     (dout_en)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed scenarios plus random
// traffic, compared cycle by cycle against a bit-queue reference model.
module tb_serial_pattern_tx;
    import serial_tx_pkg::*;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_pattern;
    logic [3:0] load_len;
    logic [3:0] load_reps;
    logic       abort;
    logic       dout;
    logic       dout_en;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int n_cmp;
    int n_err;

    // Reference model: bits still to be sent (head is on dout now) and a
    // flag for the one-cycle completion slot.
    logic exp_q[$];
    logic m_done;

    // Observation log used by the pattern-detector checks.
    logic obs_q[$];
    int   done_cnt;

    serial_pattern_tx dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_pattern(load_pattern),
        .load_len    (load_len),
        .load_reps   (load_reps),
        .abort       (abort),
        .dout        (dout),
        .dout_en     (dout_en),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_done = 1'b0;
    endtask

    task automatic model_advance(input logic v, input logic ab, input load_req_t req);
        int l;
        if (exp_q.size() != 0) begin
            if (ab) begin
                exp_q.delete();
            end else begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (v && !ab) begin
            l = (int'(req.len) > 8) ? 8 : int'(req.len);
            if (l == 0 || req.reps == 0) begin
                m_done = 1'b1;
            end else begin
                for (int r = 0; r < int'(req.reps); r++)
                    for (int b = l - 1; b >= 0; b--)
                        exp_q.push_back(req.pattern[b]);
            end
        end
    endtask

    task automatic check_outputs(input logic ab);
        logic e_en, e_dout, e_done, e_busy, e_ready;
        e_en    = (exp_q.size() != 0);
        e_dout  = e_en ? exp_q[0] : 1'b0;
        e_done  = !e_en && m_done;
        e_busy  = e_en || m_done;
        e_ready = !e_busy && !ab;
        check_eq("dout_en", 32'(dout_en), 32'(e_en));
        check_eq("dout", 32'(dout), 32'(e_dout));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("load_ready", 32'(load_ready), 32'(e_ready));
    endtask

    task automatic cycle(input logic v, input logic ab, input load_req_t req);
        @(negedge clk);
        load_valid   = v;
        abort        = ab;
        load_pattern = req.pattern;
        load_len     = req.len;
        load_reps    = req.reps;
        #1;
        check_outputs(ab);
        if (dout_en) obs_q.push_back(dout);
        if (done) done_cnt++;
        @(posedge clk);
        model_advance(v, ab, req);
    endtask

    task automatic idle(input int n);
        load_req_t z;
        z = '0;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, z);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        load_req_t q;
        q.pattern = p;
        q.len     = l;
        q.reps    = r;
        cycle(1'b1, 1'b0, q);
    endtask

    initial begin
        load_req_t q;
        int ov, nov, i;
        n_cmp = 0;
        n_err = 0;
        done_cnt = 0;
        rst = 1'b1;
        load_valid = 1'b0;
        abort = 1'b0;
        load_pattern = '0;
        load_len = '0;
        load_reps = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_dout_en", 32'(dout_en), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic send
        idle(1);
        load(8'h0A, 4'd4, 4'd1);
        idle(6);

        // Back-to-back repeats and detector view of the stream
        obs_q.delete();
        done_cnt = 0;
        load(8'h0A, 4'd4, 4'd3);
        idle(15);
        check_eq("rep_bits", 32'(obs_q.size()), 32'd12);
        ov = 0;
        nov = 0;
        for (int k = 0; k + 3 < obs_q.size(); k++)
            if ({obs_q[k], obs_q[k+1], obs_q[k+2], obs_q[k+3]} == 4'b1010) ov++;
        i = 0;
        while (i + 3 < obs_q.size()) begin
            if ({obs_q[i], obs_q[i+1], obs_q[i+2], obs_q[i+3]} == 4'b1010) begin
                nov++;
                i += 4;
            end else begin
                i++;
            end
        end
        check_eq("overlap_hits", 32'(ov), 32'd5);
        check_eq("nonoverlap_hits", 32'(nov), 32'd3);
        check_eq("rep_done_pulses", 32'(done_cnt), 32'd1);

        // Degenerate loads and length clamp
        obs_q.delete();
        load(8'hFF, 4'd0, 4'd5);
        idle(2);
        load(8'hFF, 4'd3, 4'd0);
        idle(2);
        check_eq("degen_bits", 32'(obs_q.size()), 32'd0);
        obs_q.delete();
        load(8'hA5, 4'd15, 4'd1);
        idle(11);
        check_eq("clamp_bits", 32'(obs_q.size()), 32'd8);

        // Abort on the third bit, then reload straight away
        done_cnt = 0;
        load(8'hB5, 4'd8, 4'd2);
        idle(2);
        q = '0;
        cycle(1'b0, 1'b1, q);
        load(8'h0A, 4'd4, 4'd1);
        idle(6);
        check_eq("abort_done_pulses", 32'(done_cnt), 32'd1);

        // Asynchronous reset between edges during bit 2
        load(8'h0A, 4'd4, 4'd1);
        idle(1);
        @(negedge clk);
        #1;
        check_eq("pre_rst_dout_en", 32'(dout_en), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_dout", 32'(dout), 32'd0);
        check_eq("async_dout_en", 32'(dout_en), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        idle(1);
        load(8'h0A, 4'd4, 4'd1);
        idle(6);

        // load_valid held during a transmission with a different pattern
        load(8'h0A, 4'd4, 4'd1);
        q.pattern = 8'h5C;
        q.len     = 4'd8;
        q.reps    = 4'd1;
        for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, q);
        idle(3);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            q.pattern = 8'($urandom_range(0, 255));
            q.len     = 4'($urandom_range(0, 15));
            q.reps    = 4'($urandom_range(0, 3));
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), q);
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
